// File: rtl/vscale_dtcm_arbiter_if.sv
// ---------------------------------------------------------------------------
// vscale_dtcm_arbiter_if
//
// Purpose: bundles every bus-level signal around the DTCM arbiter into one
// interface. It covers both requester ports (core "c_" and secondary "d_")
// and the single-port DTCM macro port ("dtcm_").
//
// Modports:
//   master : the requester / memory side. It drives requests and the DTCM
//            read data, and observes grants, read returns and DTCM strobes.
//   slave  : the arbiter side (vscale_dtcm_arbiter).
//
// Signal summary (per requester, x = c | d):
//   x_req     1   request
//   x_wen     1   write (1) / read (0)
//   x_size    3   0 byte, 1 half, >=2 word
//   x_addr    16  byte address within the DTCM
//   x_wdata   32  lane-aligned write data
//   x_gnt     1   request accepted this cycle
//   x_rvalid  1   read data valid (cycle after the read grant)
//   x_rdata   32  read data, zero whenever x_rvalid is low
// DTCM port:
//   dtcm_ren / dtcm_raddr[13:0]               read strobe and word address
//   dtcm_rdata[31:0]                           read data, one cycle after ren
//   dtcm_wen / dtcm_waddr[13:0] / dtcm_wdata   write strobe, address and data
// ---------------------------------------------------------------------------
interface vscale_dtcm_arbiter_if;

    // core data port
    logic        c_req;
    logic        c_wen;
    logic [2:0]  c_size;
    logic [15:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_gnt;
    logic        c_rvalid;
    logic [31:0] c_rdata;

    // secondary (DMA / debug) port
    logic        d_req;
    logic        d_wen;
    logic [2:0]  d_size;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    // DTCM macro port
    logic        dtcm_ren;
    logic [13:0] dtcm_raddr;
    logic [31:0] dtcm_rdata;
    logic        dtcm_wen;
    logic [13:0] dtcm_waddr;
    logic [31:0] dtcm_wdata;

    modport master (
        output c_req, c_wen, c_size, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_wen, d_size, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  dtcm_ren, dtcm_raddr, dtcm_wen, dtcm_waddr, dtcm_wdata,
        output dtcm_rdata
    );

    modport slave (
        input  c_req, c_wen, c_size, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_wen, d_size, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output dtcm_ren, dtcm_raddr, dtcm_wen, dtcm_waddr, dtcm_wdata,
        input  dtcm_rdata
    );

endinterface

// File: rtl/vscale_dtcm_arbiter.sv
// ---------------------------------------------------------------------------
// vscale_dtcm_arbiter
//
// Purpose: shares the single-port DTCM (1-cycle read latency) between the
// core data port and a secondary master. Accesses are serialised. Byte and
// halfword writes become an internal read-modify-write: the grant cycle
// reads the target word, and the following cycle writes back the merged word.
//
// Ports:
//   clk_i     rising-edge clock
//   reset_n   synchronous active-low reset
//   bus       vscale_dtcm_arbiter_if.slave (both requesters + DTCM macro)
//
// Parameter:
//   MAX_WAIT  number of consecutive refused cycles after which the secondary
//             requester wins over the core (>= 1)
//
// State table:
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | arbitrate; reads and word writes finish in the grant cycle
//   ST_RMW   | write back the merged word of a byte/half write; no grants
// ---------------------------------------------------------------------------
module vscale_dtcm_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_n,
    vscale_dtcm_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic               rv_c_q;
    logic               rv_d_q;
    logic [13:0]        rmw_waddr_q;
    logic [1:0]         rmw_lane_q;
    logic               rmw_half_q;
    logic [31:0]        rmw_wdata_q;

    logic               idle;
    logic               in_rmw;
    logic               d_prio;
    logic               c_win;
    logic               d_win;
    logic               acc;
    logic               sel_wen;
    logic [2:0]         sel_size;
    logic [15:0]        sel_addr;
    logic [31:0]        sel_wdata;
    logic               sel_word;
    logic               rd_acc;
    logic               wr_word;
    logic               wr_sub;
    logic [31:0]        rmw_mask;
    logic [31:0]        rmw_merged;

    // Outputs are forced quiet while reset_n is low, including the cycle in
    // which a pending RMW write is abandoned.
    assign idle   = reset_n && (state_q == ST_IDLE);
    assign in_rmw = reset_n && (state_q == ST_RMW);

    // Core wins by default; the secondary overrides it only once it has been
    // refused MAX_WAIT cycles in a row.
    assign d_prio = bus.d_req && (wait_cnt_q == WAIT_LIMIT);
    assign c_win  = idle && bus.c_req && !d_prio;
    assign d_win  = idle && bus.d_req && !c_win;
    assign acc    = c_win || d_win;

    always_comb begin
        sel_wen   = bus.c_wen;
        sel_size  = bus.c_size;
        sel_addr  = bus.c_addr;
        sel_wdata = bus.c_wdata;
        if (d_win) begin
            sel_wen   = bus.d_wen;
            sel_size  = bus.d_size;
            sel_addr  = bus.d_addr;
            sel_wdata = bus.d_wdata;
        end
    end

    assign sel_word = |sel_size[2:1];
    assign rd_acc   = acc && !sel_wen;
    assign wr_word  = acc && sel_wen && sel_word;
    assign wr_sub   = acc && sel_wen && !sel_word;

    // Half lane is selected by addr[1] only; addr[0] is ignored for halves.
    always_comb begin
        rmw_mask = 32'h0000_00FF << {rmw_lane_q, 3'b000};
        if (rmw_half_q) begin
            rmw_mask = rmw_lane_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        end
    end

    assign rmw_merged = (bus.dtcm_rdata & ~rmw_mask) | (rmw_wdata_q & rmw_mask);

    assign bus.c_gnt      = c_win;
    assign bus.d_gnt      = d_win;

    assign bus.dtcm_ren   = rd_acc || wr_sub;
    assign bus.dtcm_raddr = sel_addr[15:2];
    assign bus.dtcm_wen   = wr_word || in_rmw;
    assign bus.dtcm_waddr = in_rmw ? rmw_waddr_q : sel_addr[15:2];
    assign bus.dtcm_wdata = in_rmw ? rmw_merged  : sel_wdata;

    assign bus.c_rvalid   = reset_n && rv_c_q;
    assign bus.d_rvalid   = reset_n && rv_d_q;
    assign bus.c_rdata    = bus.c_rvalid ? bus.dtcm_rdata : 32'h0;
    assign bus.d_rdata    = bus.d_rvalid ? bus.dtcm_rdata : 32'h0;

    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            rv_c_q      <= 1'b0;
            rv_d_q      <= 1'b0;
            rmw_waddr_q <= '0;
            rmw_lane_q  <= '0;
            rmw_half_q  <= 1'b0;
            rmw_wdata_q <= '0;
        end else begin
            // Read data returns one cycle after the grant to whoever won.
            rv_c_q <= c_win && !sel_wen;
            rv_d_q <= d_win && !sel_wen;

            // Refusals keep counting through RMW cycles as well.
            if (!bus.d_req || d_win) begin
                wait_cnt_q <= '0;
            end else if (wait_cnt_q != WAIT_LIMIT) begin
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            end

            if (state_q == ST_IDLE) begin
                if (wr_sub) begin
                    state_q     <= ST_RMW;
                    rmw_waddr_q <= sel_addr[15:2];
                    rmw_lane_q  <= sel_addr[1:0];
                    rmw_half_q  <= sel_size[0];
                    rmw_wdata_q <= sel_wdata;
                end
            end else begin
                state_q <= ST_IDLE;
            end
        end
    end

endmodule
